// File: rtl/cpu_pkg.sv
// Shared types and encodings for the datapath controller: FSM states,
// instruction opcode/sub-op constants and the imm8 sign-extension helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_ALU       = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] CMP = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] MVN = 2'b11;

    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;

    function automatic logic [15:0] sext8(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/datapath_controller_if.sv
// Control bundle from the controller to the datapath: register enables,
// selects, register-file addressing, ALU/shift control and the immediate.
interface datapath_controller_if;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        vsel;
    logic        write;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [15:0] datapath_in;

    modport master (
        output loada, loadb, loadc, loads, asel, bsel, vsel, write,
        output ALUop, shift, readnum, writenum, datapath_in
    );

    modport slave (
        input loada, loadb, loadc, loads, asel, bsel, vsel, write,
        input ALUop, shift, readnum, writenum, datapath_in
    );
endinterface

// File: rtl/datapath_controller_instr_dec.sv
// Purely combinational instruction decoder: splits the IR into its fields
// and classifies the encoding so the FSM only has to test a few flags.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [15:0] sximm8,
    output logic        is_mov_imm,
    output logic        is_mov_reg,
    output logic        is_two_src,
    output logic        is_cmp,
    output logic        is_mvn
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = sext8(ir[7:0]);

    // Two-source ops (ADD/CMP/AND) need Rn fetched into A before Rm.
    assign is_mov_imm = (opcode == OPC_MOV) && (op == MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == MOV_REG);
    assign is_two_src = (opcode == OPC_ALU) && (op != MVN);
    assign is_cmp     = (opcode == OPC_ALU) && (op == CMP);
    assign is_mvn     = (opcode == OPC_ALU) && (op == MVN);

endmodule

// File: rtl/datapath_controller.sv
// Instruction register plus Moore control FSM that sequences the datapath
// through operand fetch, ALU and write-back for one instruction at a time.
module datapath_controller
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            in,
    input  logic                   load,
    input  logic                   s,
    output logic                   w,
    datapath_controller_if.master  dp
);

    logic [15:0] ir_reg;
    state_t      state_reg;
    state_t      state_next;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [15:0] sximm8;
    logic        is_mov_imm;
    logic        is_mov_reg;
    logic        is_two_src;
    logic        is_cmp;
    logic        is_mvn;

    instr_dec u_dec (
        .ir         (ir_reg),
        .opcode     (opcode),
        .op         (op),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .sh         (sh),
        .sximm8     (sximm8),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_two_src (is_two_src),
        .is_cmp     (is_cmp),
        .is_mvn     (is_mvn)
    );

    // The IR only accepts a new word while idle, so a busy instruction
    // always completes with the encoding it started with.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_WAIT;
            ir_reg    <= 16'h0000;
        end else begin
            state_reg <= state_next;
            if (load && (state_reg == S_WAIT))
                ir_reg <= in;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_WAIT:      if (s) state_next = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)                 state_next = S_WRITE_IMM;
                else if (is_two_src)            state_next = S_GET_A;
                else if (is_mov_reg || is_mvn)  state_next = S_GET_B;
                else                            state_next = S_WAIT;
            end
            S_GET_A:     state_next = S_GET_B;
            S_GET_B:     state_next = S_ALU;
            S_ALU:       state_next = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_next = S_WAIT;
            S_WRITE_IMM: state_next = S_WAIT;
            default:     state_next = S_WAIT;
        endcase
    end

    assign dp.datapath_in = sximm8;

    always_comb begin
        w           = 1'b0;
        dp.loada    = 1'b0;
        dp.loadb    = 1'b0;
        dp.loadc    = 1'b0;
        dp.loads    = 1'b0;
        dp.asel     = 1'b0;
        dp.bsel     = 1'b0;
        dp.vsel     = 1'b0;
        dp.write    = 1'b0;
        dp.ALUop    = 2'b00;
        dp.shift    = 2'b00;
        dp.readnum  = 3'd0;
        dp.writenum = 3'd0;
        unique case (state_reg)
            S_WAIT: w = 1'b1;
            S_GET_A: begin
                dp.readnum = rn;
                dp.loada   = 1'b1;
            end
            S_GET_B: begin
                dp.readnum = rm;
                dp.loadb   = 1'b1;
            end
            // MOV reg is executed as 0 + shifted Rm, hence asel with ADD.
            S_ALU: begin
                dp.shift = sh;
                dp.ALUop = (opcode == OPC_ALU) ? op : ADD;
                dp.asel  = is_mov_reg;
                dp.loads = is_cmp;
                dp.loadc = !is_cmp;
            end
            S_WRITE_REG: begin
                dp.writenum = rd;
                dp.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                dp.writenum = rn;
                dp.write    = 1'b1;
                dp.vsel     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench: stimulus queues the expected per-cycle control vector,
// a monitor compares it against the DUT shortly after every rising edge.
module tb_datapath_controller;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        load;
    logic        s;
    logic        w;

    datapath_controller_if dpif ();

    datapath_controller dut (
        .clk   (clk),
        .reset (reset),
        .in    (instr),
        .load  (load),
        .s     (s),
        .w     (w),
        .dp    (dpif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bit order: w, loada, loadb, loadc, loads, asel, bsel, vsel, write
    localparam logic [8:0] C_W  = 9'b1_0000_0000;
    localparam logic [8:0] C_LA = 9'b0_1000_0000;
    localparam logic [8:0] C_LB = 9'b0_0100_0000;
    localparam logic [8:0] C_LC = 9'b0_0010_0000;
    localparam logic [8:0] C_LS = 9'b0_0001_0000;
    localparam logic [8:0] C_AS = 9'b0_0000_1000;
    localparam logic [8:0] C_VS = 9'b0_0000_0010;
    localparam logic [8:0] C_WR = 9'b0_0000_0001;

    typedef struct {
        logic [34:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    logic [34:0] act;
    assign act = {w, dpif.loada, dpif.loadb, dpif.loadc, dpif.loads, dpif.asel,
                  dpif.bsel, dpif.vsel, dpif.write, dpif.ALUop, dpif.shift,
                  dpif.readnum, dpif.writenum, dpif.datapath_in};

    function automatic logic [34:0] ev(input logic [8:0] c, input logic [1:0] a,
                                       input logic [1:0] shf, input logic [2:0] rn,
                                       input logic [2:0] wn, input logic [15:0] dpv);
        return {c, a, shf, rn, wn, dpv};
    endfunction

    task automatic push(input logic [34:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.tag, act, e.v);
            end
        end
    end

    // Called at a negedge while idle: load the IR and expect WAIT with the new imm.
    task automatic load_ir(input logic [15:0] word);
        instr = word;
        load  = 1'b1;
        s     = 1'b0;
        push(ev(C_W, 2'b00, 2'b00, 3'd0, 3'd0, {{8{word[7]}}, word[7:0]}), "load_wait");
        @(negedge clk);
        load = 1'b0;
    endtask

    // Raise s for 'hold' edges and run n cycles; optional same-edge load,
    // load during GET_A, and a one-edge reset pulse after cycle rst_at.
    task automatic go(input int n, input int hold, input logic ld, input logic [15:0] word,
                      input logic busy, input int rst_at, input string tag);
        $display("txn %s", tag);
        if (ld) begin
            instr = word;
            load  = 1'b1;
        end
        s = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) load = 1'b0;
            if (i == hold) s = 1'b0;
            if (busy && i == 2) begin
                instr = 16'hD0FF;
                load  = 1'b1;
            end
            if (busy && i == 3) load = 1'b0;
            if (i == rst_at) reset = 1'b1;
            if (i == rst_at + 1) reset = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        instr = 16'h0000;
        load  = 1'b0;
        s     = 1'b0;
        push(ev(C_W, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000), "reset0");
        push(ev(C_W, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000), "reset1");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // MOV R3,#-2
        load_ir(16'hD3FE);
        push(ev(9'd0,        2'b00, 2'b00, 3'd0, 3'd0, 16'hFFFE), "movi_dec");
        push(ev(C_VS | C_WR, 2'b00, 2'b00, 3'd0, 3'd3, 16'hFFFE), "movi_wimm");
        push(ev(C_W,         2'b00, 2'b00, 3'd0, 3'd0, 16'hFFFE), "movi_done");
        go(3, 1, 1'b0, 16'h0000, 1'b0, 0, "MOV R3,#-2");

        // ADD R2,R5,R3 with a load attempt during GET_A
        load_ir(16'hA543);
        push(ev(9'd0,  2'b00, 2'b00, 3'd0, 3'd0, 16'h0043), "add_dec");
        push(ev(C_LA,  2'b00, 2'b00, 3'd5, 3'd0, 16'h0043), "add_geta");
        push(ev(C_LB,  2'b00, 2'b00, 3'd3, 3'd0, 16'h0043), "add_getb");
        push(ev(C_LC,  2'b00, 2'b00, 3'd0, 3'd0, 16'h0043), "add_alu");
        push(ev(C_WR,  2'b00, 2'b00, 3'd0, 3'd2, 16'h0043), "add_wr");
        push(ev(C_W,   2'b00, 2'b00, 3'd0, 3'd0, 16'h0043), "add_done");
        go(6, 1, 1'b0, 16'h0000, 1'b1, 0, "ADD R2,R5,R3 (busy load)");

        // CMP R1,R1
        load_ir(16'hA901);
        push(ev(9'd0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0001), "cmp_dec");
        push(ev(C_LA, 2'b00, 2'b00, 3'd1, 3'd0, 16'h0001), "cmp_geta");
        push(ev(C_LB, 2'b00, 2'b00, 3'd1, 3'd0, 16'h0001), "cmp_getb");
        push(ev(C_LS, 2'b01, 2'b00, 3'd0, 3'd0, 16'h0001), "cmp_alu");
        push(ev(C_W,  2'b00, 2'b00, 3'd0, 3'd0, 16'h0001), "cmp_done");
        go(5, 1, 1'b0, 16'h0000, 1'b0, 0, "CMP R1,R1");

        // MOV R7,R3,LSL#1 loaded on the same edge as start
        push(ev(9'd0,        2'b00, 2'b00, 3'd0, 3'd0, 16'hFFEB), "movr_dec");
        push(ev(C_LB,        2'b00, 2'b00, 3'd3, 3'd0, 16'hFFEB), "movr_getb");
        push(ev(C_AS | C_LC, 2'b00, 2'b01, 3'd0, 3'd0, 16'hFFEB), "movr_alu");
        push(ev(C_WR,        2'b00, 2'b00, 3'd0, 3'd7, 16'hFFEB), "movr_wr");
        push(ev(C_W,         2'b00, 2'b00, 3'd0, 3'd0, 16'hFFEB), "movr_done");
        go(5, 1, 1'b1, 16'hC0EB, 1'b0, 0, "MOV R7,R3,LSL#1 (load+s)");

        // MVN R4,R6,LSR#1
        load_ir(16'hB896);
        push(ev(9'd0, 2'b00, 2'b00, 3'd0, 3'd0, 16'hFF96), "mvn_dec");
        push(ev(C_LB, 2'b00, 2'b00, 3'd6, 3'd0, 16'hFF96), "mvn_getb");
        push(ev(C_LC, 2'b11, 2'b10, 3'd0, 3'd0, 16'hFF96), "mvn_alu");
        push(ev(C_WR, 2'b00, 2'b00, 3'd0, 3'd4, 16'hFF96), "mvn_wr");
        push(ev(C_W,  2'b00, 2'b00, 3'd0, 3'd0, 16'hFF96), "mvn_done");
        go(5, 1, 1'b0, 16'h0000, 1'b0, 0, "MVN R4,R6,LSR#1");

        // AND R1,R2,R7
        load_ir(16'hB227);
        push(ev(9'd0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0027), "and_dec");
        push(ev(C_LA, 2'b00, 2'b00, 3'd2, 3'd0, 16'h0027), "and_geta");
        push(ev(C_LB, 2'b00, 2'b00, 3'd7, 3'd0, 16'h0027), "and_getb");
        push(ev(C_LC, 2'b10, 2'b00, 3'd0, 3'd0, 16'h0027), "and_alu");
        push(ev(C_WR, 2'b00, 2'b00, 3'd0, 3'd1, 16'h0027), "and_wr");
        push(ev(C_W,  2'b00, 2'b00, 3'd0, 3'd0, 16'h0027), "and_done");
        go(6, 1, 1'b0, 16'h0000, 1'b0, 0, "AND R1,R2,R7");

        // s held high: MOV imm runs twice back to back
        load_ir(16'hD3FE);
        push(ev(9'd0,        2'b00, 2'b00, 3'd0, 3'd0, 16'hFFFE), "hold_dec1");
        push(ev(C_VS | C_WR, 2'b00, 2'b00, 3'd0, 3'd3, 16'hFFFE), "hold_wimm1");
        push(ev(C_W,         2'b00, 2'b00, 3'd0, 3'd0, 16'hFFFE), "hold_wait1");
        push(ev(9'd0,        2'b00, 2'b00, 3'd0, 3'd0, 16'hFFFE), "hold_dec2");
        push(ev(C_VS | C_WR, 2'b00, 2'b00, 3'd0, 3'd3, 16'hFFFE), "hold_wimm2");
        push(ev(C_W,         2'b00, 2'b00, 3'd0, 3'd0, 16'hFFFE), "hold_done");
        go(6, 4, 1'b0, 16'h0000, 1'b0, 0, "MOV R3,#-2 (s held)");

        // Reset during GET_B of an ADD
        load_ir(16'hA543);
        push(ev(9'd0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0043), "rst_dec");
        push(ev(C_LA, 2'b00, 2'b00, 3'd5, 3'd0, 16'h0043), "rst_geta");
        push(ev(C_LB, 2'b00, 2'b00, 3'd3, 3'd0, 16'h0043), "rst_getb");
        push(ev(C_W,  2'b00, 2'b00, 3'd0, 3'd0, 16'h0000), "rst_wait");
        go(4, 1, 1'b0, 16'h0000, 1'b0, 3, "ADD aborted by reset");

        // IR=0 is illegal: DECODE straight back to WAIT
        push(ev(9'd0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000), "ill_dec");
        push(ev(C_W,  2'b00, 2'b00, 3'd0, 3'd0, 16'h0000), "ill_wait");
        go(2, 1, 1'b0, 16'h0000, 1'b0, 0, "illegal IR=0");

        push(ev(C_W, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000), "idle");
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
